// File: rtl/dev_arb_pkg.sv
// Shared definitions for the two-master device-port arbiter.
package dev_arb_pkg;

  // Arbiter FSM encoding; also exposed on the top-level debug state output.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Cycles a downstream transaction may spend in WAIT before forced completion.
  localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/dev_req_latch.sv
// Per-requester capture register: holds one request until the arbiter retires it.
module dev_req_latch
  import dev_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              strobe_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic              rw_i,
  input  logic [XLEN/8-1:0] byte_enable_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic              clear_i,
  output logic              pending_o,
  output logic [XLEN-1:0]   addr_o,
  output logic              rw_o,
  output logic [XLEN/8-1:0] byte_enable_o,
  output logic [XLEN-1:0]   data_o
);

  logic              pending_q;
  logic [XLEN-1:0]   addr_q;
  logic              rw_q;
  logic [XLEN/8-1:0] be_q;
  logic [XLEN-1:0]   data_q;

  // Capture a request only when none is held; a strobe while pending is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      be_q      <= '0;
      data_q    <= '0;
    end else if (clear_i) begin
      pending_q <= 1'b0;
    end else if (strobe_i && !pending_q) begin
      pending_q <= 1'b1;
      addr_q    <= addr_i;
      rw_q      <= rw_i;
      be_q      <= byte_enable_i;
      data_q    <= data_i;
    end
  end

  assign pending_o     = pending_q;
  assign addr_o        = addr_q;
  assign rw_o          = rw_q;
  assign byte_enable_o = be_q;
  assign data_o        = data_q;

endmodule

// File: rtl/dev_port_arbiter.sv
// Round-robin arbiter sharing one device-I/O port between two masters.
// Handshake: each side uses one-cycle strobe / data_ready pulses; a requester
// holds at most one request and waits for its data_ready before strobing again.
// Exactly one downstream transaction is outstanding at a time; a watchdog
// forces an error completion if the slave never answers.
module dev_port_arbiter
  import dev_arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              S0_strobe_i,
  input  logic [XLEN-1:0]   S0_addr_i,
  input  logic              S0_rw_i,
  input  logic [XLEN/8-1:0] S0_byte_enable_i,
  input  logic [XLEN-1:0]   S0_data_i,
  output logic              S0_data_ready_o,
  output logic [XLEN-1:0]   S0_data_o,
  output logic              S0_error_o,
  input  logic              S1_strobe_i,
  input  logic [XLEN-1:0]   S1_addr_i,
  input  logic              S1_rw_i,
  input  logic [XLEN/8-1:0] S1_byte_enable_i,
  input  logic [XLEN-1:0]   S1_data_i,
  output logic              S1_data_ready_o,
  output logic [XLEN-1:0]   S1_data_o,
  output logic              S1_error_o,
  output logic              M_strobe_o,
  output logic [XLEN-1:0]   M_addr_o,
  output logic              M_rw_o,
  output logic [XLEN/8-1:0] M_byte_enable_o,
  output logic [XLEN-1:0]   M_data_o,
  input  logic              M_data_ready_i,
  input  logic [XLEN-1:0]   M_data_i,
  output logic [1:0]        dbg_state_o
);

  // Latched requests.
  logic [1:0]        pend;
  logic [1:0]        clear;
  logic [XLEN-1:0]   l_addr [2];
  logic              l_rw   [2];
  logic [XLEN/8-1:0] l_be   [2];
  logic [XLEN-1:0]   l_data [2];

  dev_req_latch #(.XLEN(XLEN)) u_req0 (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .strobe_i      (S0_strobe_i),
    .addr_i        (S0_addr_i),
    .rw_i          (S0_rw_i),
    .byte_enable_i (S0_byte_enable_i),
    .data_i        (S0_data_i),
    .clear_i       (clear[0]),
    .pending_o     (pend[0]),
    .addr_o        (l_addr[0]),
    .rw_o          (l_rw[0]),
    .byte_enable_o (l_be[0]),
    .data_o        (l_data[0])
  );

  dev_req_latch #(.XLEN(XLEN)) u_req1 (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .strobe_i      (S1_strobe_i),
    .addr_i        (S1_addr_i),
    .rw_i          (S1_rw_i),
    .byte_enable_i (S1_byte_enable_i),
    .data_i        (S1_data_i),
    .clear_i       (clear[1]),
    .pending_o     (pend[1]),
    .addr_o        (l_addr[1]),
    .rw_o          (l_rw[1]),
    .byte_enable_o (l_be[1]),
    .data_o        (l_data[1])
  );

  // Arbiter state.
  arb_state_e        state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic [TW-1:0]     wd_q;
  logic [TW-1:0]     wd_d;
  logic              grant_d;
  logic              timeout_hit;
  logic              done;

  // Registered outputs.
  logic              m_strobe_q;
  logic [XLEN-1:0]   m_addr_q;
  logic              m_rw_q;
  logic [XLEN/8-1:0] m_be_q;
  logic [XLEN-1:0]   m_data_q;
  logic [1:0]        rdy_q;
  logic [1:0]        err_q;
  logic [XLEN-1:0]   rdata_q [2];

  // Grant selection, watchdog compare and retirement of the granted latch.
  // The watchdog "reaches" TIMEOUT-1 in the cycle its incremented value would
  // equal TIMEOUT-1, so the error pulse lands exactly TIMEOUT cycles after
  // the downstream strobe.
  always_comb begin
    grant_d     = (&pend) ? ~last_grant_q : ~pend[0];
    wd_d        = wd_q + TW'(1);
    timeout_hit = (wd_d == TW'(TIMEOUT - 1));
    done        = (state_q == WAIT) && (M_data_ready_i || timeout_hit);
    clear       = 2'b00;
    if (done) clear[grant_q] = 1'b1;
  end

  // Arbitration FSM with watchdog and registered downstream/reply outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wd_q         <= '0;
      m_strobe_q   <= 1'b0;
      m_addr_q     <= '0;
      m_rw_q       <= 1'b0;
      m_be_q       <= '0;
      m_data_q     <= '0;
      rdy_q        <= '0;
      err_q        <= '0;
      rdata_q[0]   <= '0;
      rdata_q[1]   <= '0;
    end else begin
      rdy_q <= '0;
      case (state_q)
        IDLE: begin
          if (|pend) begin
            grant_q    <= grant_d;
            m_strobe_q <= 1'b1;
            m_addr_q   <= l_addr[grant_d];
            m_rw_q     <= l_rw[grant_d];
            m_be_q     <= l_be[grant_d];
            m_data_q   <= l_data[grant_d];
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          m_strobe_q <= 1'b0;
          wd_q       <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          wd_q <= wd_d;
          if (M_data_ready_i) begin
            rdy_q[grant_q]   <= 1'b1;
            err_q[grant_q]   <= 1'b0;
            rdata_q[grant_q] <= M_data_i;
            last_grant_q     <= grant_q;
            state_q          <= IDLE;
          end else if (timeout_hit) begin
            rdy_q[grant_q]   <= 1'b1;
            err_q[grant_q]   <= 1'b1;
            rdata_q[grant_q] <= '0;
            last_grant_q     <= grant_q;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M_strobe_o      = m_strobe_q;
  assign M_addr_o        = m_addr_q;
  assign M_rw_o          = m_rw_q;
  assign M_byte_enable_o = m_be_q;
  assign M_data_o        = m_data_q;
  assign S0_data_ready_o = rdy_q[0];
  assign S1_data_ready_o = rdy_q[1];
  assign S0_error_o      = err_q[0];
  assign S1_error_o      = err_q[1];
  assign S0_data_o       = rdata_q[0];
  assign S1_data_o       = rdata_q[1];
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_dev_port_arbiter.sv
// Directed bench for dev_port_arbiter (TIMEOUT=16).
module tb_dev_port_arbiter;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        S0_strobe_i, S1_strobe_i, S0_rw_i, S1_rw_i;
  logic [31:0] S0_addr_i, S1_addr_i, S0_data_i, S1_data_i;
  logic [3:0]  S0_byte_enable_i, S1_byte_enable_i;
  logic        S0_data_ready_o, S1_data_ready_o, S0_error_o, S1_error_o;
  logic [31:0] S0_data_o, S1_data_o;
  logic        M_strobe_o, M_rw_o, M_data_ready_i;
  logic [31:0] M_addr_o, M_data_o, M_data_i;
  logic [3:0]  M_byte_enable_o;
  logic [1:0]  dbg_state_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  int rdy0_cnt = 0;
  int rdy1_cnt = 0;
  int mstb_cnt = 0;

  dev_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .S0_strobe_i      (S0_strobe_i),
    .S0_addr_i        (S0_addr_i),
    .S0_rw_i          (S0_rw_i),
    .S0_byte_enable_i (S0_byte_enable_i),
    .S0_data_i        (S0_data_i),
    .S0_data_ready_o  (S0_data_ready_o),
    .S0_data_o        (S0_data_o),
    .S0_error_o       (S0_error_o),
    .S1_strobe_i      (S1_strobe_i),
    .S1_addr_i        (S1_addr_i),
    .S1_rw_i          (S1_rw_i),
    .S1_byte_enable_i (S1_byte_enable_i),
    .S1_data_i        (S1_data_i),
    .S1_data_ready_o  (S1_data_ready_o),
    .S1_data_o        (S1_data_o),
    .S1_error_o       (S1_error_o),
    .M_strobe_o       (M_strobe_o),
    .M_addr_o         (M_addr_o),
    .M_rw_o           (M_rw_o),
    .M_byte_enable_o  (M_byte_enable_o),
    .M_data_o         (M_data_o),
    .M_data_ready_i   (M_data_ready_i),
    .M_data_i         (M_data_i),
    .dbg_state_o      (dbg_state_o)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (S0_data_ready_o === 1'b1) rdy0_cnt++;
    if (S1_data_ready_o === 1'b1) rdy1_cnt++;
    if (M_strobe_o === 1'b1) mstb_cnt++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    rdy0_cnt = 0;
    rdy1_cnt = 0;
    mstb_cnt = 0;
  endtask

  task automatic req0(input logic [31:0] a, input logic rw, input logic [31:0] d);
    S0_addr_i = a; S0_rw_i = rw; S0_data_i = d; S0_byte_enable_i = 4'hF; S0_strobe_i = 1'b1;
  endtask

  task automatic req1(input logic [31:0] a, input logic rw, input logic [31:0] d);
    S1_addr_i = a; S1_rw_i = rw; S1_data_i = d; S1_byte_enable_i = 4'hF; S1_strobe_i = 1'b1;
  endtask

  task automatic drop();
    S0_strobe_i = 1'b0;
    S1_strobe_i = 1'b0;
  endtask

  // Slave reply in the current cycle; returns in the following cycle.
  task automatic respond(input logic [31:0] rd);
    M_data_ready_i = 1'b1;
    M_data_i = rd;
    tick();
    M_data_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    tick();
  endtask

  // Bounded wait until the cycle in which M_strobe_o is high.
  task automatic wait_mstrobe();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (M_strobe_o === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    vec_cnt++;
    if (!seen) begin err_cnt++; $display("FAIL wait_mstrobe: got no M_strobe_o within 40 cycles, required one"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick_n(2);
    vec_cnt++; if (M_strobe_o !== 1'b0) begin err_cnt++; $display("FAIL rst_mstrobe: got %b want 0", M_strobe_o); end
    vec_cnt++; if (M_addr_o !== 32'h0) begin err_cnt++; $display("FAIL rst_maddr: got %h want 0", M_addr_o); end
    vec_cnt++; if (M_data_o !== 32'h0 || M_rw_o !== 1'b0 || M_byte_enable_o !== 4'h0) begin err_cnt++; $display("FAIL rst_mfields: got %h/%b/%h want 0/0/0", M_data_o, M_rw_o, M_byte_enable_o); end
    vec_cnt++; if (S0_data_ready_o !== 1'b0 || S1_data_ready_o !== 1'b0) begin err_cnt++; $display("FAIL rst_ready: got %b%b want 00", S0_data_ready_o, S1_data_ready_o); end
    vec_cnt++; if (S0_data_o !== 32'h0 || S1_data_o !== 32'h0) begin err_cnt++; $display("FAIL rst_sdata: got %h/%h want 0/0", S0_data_o, S1_data_o); end
    vec_cnt++; if (S0_error_o !== 1'b0 || S1_error_o !== 1'b0) begin err_cnt++; $display("FAIL rst_err: got %b%b want 00", S0_error_o, S1_error_o); end
    vec_cnt++; if (dbg_state_o !== 2'd0) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", dbg_state_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    clear_counts();
    req0(32'hC000_0004, 1'b0, 32'h0);
    tick(); drop();
    vec_cnt++; if (M_strobe_o !== 1'b0) begin err_cnt++; $display("FAIL rd_mstrobe_t1: got %b want 0", M_strobe_o); end
    tick();
    vec_cnt++; if (M_strobe_o !== 1'b1) begin err_cnt++; $display("FAIL rd_mstrobe_t2: got %b want 1", M_strobe_o); end
    vec_cnt++; if (M_addr_o !== 32'hC000_0004 || M_rw_o !== 1'b0) begin err_cnt++; $display("FAIL rd_maddr: got %h/%b want c0000004/0", M_addr_o, M_rw_o); end
    tick_n(3);
    respond(32'hDEAD_BEEF);
    vec_cnt++; if (S0_data_ready_o !== 1'b1) begin err_cnt++; $display("FAIL rd_ready: got %b want 1", S0_data_ready_o); end
    vec_cnt++; if (S0_data_o !== 32'hDEAD_BEEF || S0_error_o !== 1'b0) begin err_cnt++; $display("FAIL rd_data: got %h/%b want deadbeef/0", S0_data_o, S0_error_o); end
    vec_cnt++; if (S1_data_ready_o !== 1'b0) begin err_cnt++; $display("FAIL rd_s1_quiet: got %b want 0", S1_data_ready_o); end
    tick();
    vec_cnt++; if (S0_data_ready_o !== 1'b0 || S0_data_o !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL rd_hold: got %b/%h want 0/deadbeef", S0_data_ready_o, S0_data_o); end
    tick_n(3);
    vec_cnt++; if (rdy0_cnt !== 1 || rdy1_cnt !== 0) begin err_cnt++; $display("FAIL rd_pulses: got %0d/%0d want 1/0", rdy0_cnt, rdy1_cnt); end
  endtask

  task automatic test_contention();
    do_reset();
    clear_counts();
    req0(32'h0000_0100, 1'b1, 32'h11);
    req1(32'h0000_0200, 1'b1, 32'h22);
    tick(); drop();
    tick();
    vec_cnt++; if (M_strobe_o !== 1'b1 || M_addr_o !== 32'h100) begin err_cnt++; $display("FAIL con_first: got %b/%h want 1/00000100", M_strobe_o, M_addr_o); end
    vec_cnt++; if (M_data_o !== 32'h11 || M_rw_o !== 1'b1 || M_byte_enable_o !== 4'hF) begin err_cnt++; $display("FAIL con_first_fields: got %h/%b/%h want 11/1/f", M_data_o, M_rw_o, M_byte_enable_o); end
    tick();
    vec_cnt++; if (M_strobe_o !== 1'b0 || M_addr_o !== 32'h100) begin err_cnt++; $display("FAIL con_hold: got %b/%h want 0/00000100", M_strobe_o, M_addr_o); end
    respond(32'h0000_1111);
    vec_cnt++; if (S0_data_ready_o !== 1'b1 || S1_data_ready_o !== 1'b0) begin err_cnt++; $display("FAIL con_done0: got %b%b want 10", S0_data_ready_o, S1_data_ready_o); end
    tick();
    vec_cnt++; if (M_strobe_o !== 1'b1 || M_addr_o !== 32'h200 || M_data_o !== 32'h22) begin err_cnt++; $display("FAIL con_second: got %b/%h/%h want 1/00000200/22", M_strobe_o, M_addr_o, M_data_o); end
    tick();
    respond(32'h0000_2222);
    vec_cnt++; if (S1_data_ready_o !== 1'b1 || S1_data_o !== 32'h2222) begin err_cnt++; $display("FAIL con_done1: got %b/%h want 1/00002222", S1_data_ready_o, S1_data_o); end
    // A lone M0 transaction leaves M0 as the most recent winner.
    req0(32'h0000_0104, 1'b0, 32'h0);
    tick(); drop();
    wait_mstrobe();
    tick();
    respond(32'h0000_1111);
    // Second simultaneous pair: M1 now has priority.
    req0(32'h0000_0108, 1'b1, 32'h33);
    req1(32'h0000_0208, 1'b1, 32'h44);
    tick(); drop();
    tick();
    vec_cnt++; if (M_strobe_o !== 1'b1 || M_addr_o !== 32'h208 || M_data_o !== 32'h44) begin err_cnt++; $display("FAIL con_rr_first: got %b/%h/%h want 1/00000208/44", M_strobe_o, M_addr_o, M_data_o); end
    tick();
    respond(32'h0000_2222);
    vec_cnt++; if (S1_data_ready_o !== 1'b1 || S0_data_ready_o !== 1'b0) begin err_cnt++; $display("FAIL con_rr_done1: got %b%b want 01", S0_data_ready_o, S1_data_ready_o); end
    tick();
    vec_cnt++; if (M_strobe_o !== 1'b1 || M_addr_o !== 32'h108 || M_data_o !== 32'h33) begin err_cnt++; $display("FAIL con_rr_second: got %b/%h/%h want 1/00000108/33", M_strobe_o, M_addr_o, M_data_o); end
    tick();
    respond(32'h0000_1111);
    vec_cnt++; if (S0_data_ready_o !== 1'b1 || S0_data_o !== 32'h1111) begin err_cnt++; $display("FAIL con_rr_done0: got %b/%h want 1/00001111", S0_data_ready_o, S0_data_o); end
  endtask

  task automatic test_timeout();
    tick_n(2);
    clear_counts();
    req1(32'h0000_0300, 1'b0, 32'h0);
    tick(); drop();
    tick();
    vec_cnt++; if (M_strobe_o !== 1'b1 || M_addr_o !== 32'h300) begin err_cnt++; $display("FAIL to_mstrobe: got %b/%h want 1/00000300", M_strobe_o, M_addr_o); end
    tick_n(15);
    vec_cnt++; if (S1_data_ready_o !== 1'b0 || dbg_state_o !== 2'd2) begin err_cnt++; $display("FAIL to_early: got %b/state %0d want 0/state 2", S1_data_ready_o, dbg_state_o); end
    tick();
    vec_cnt++; if (S1_data_ready_o !== 1'b1 || S1_error_o !== 1'b1) begin err_cnt++; $display("FAIL to_pulse: got %b/%b want 1/1", S1_data_ready_o, S1_error_o); end
    vec_cnt++; if (S1_data_o !== 32'h0) begin err_cnt++; $display("FAIL to_data: got %h want 0", S1_data_o); end
    vec_cnt++; if (dbg_state_o !== 2'd0) begin err_cnt++; $display("FAIL to_idle: got %0d want 0", dbg_state_o); end
    tick();
    respond(32'hFFFF_FFFF);
    tick_n(3);
    vec_cnt++; if (rdy0_cnt !== 0 || rdy1_cnt !== 1 || mstb_cnt !== 1) begin err_cnt++; $display("FAIL to_late: got %0d/%0d/%0d want 0/1/1", rdy0_cnt, rdy1_cnt, mstb_cnt); end
  endtask

  task automatic test_race();
    clear_counts();
    req1(32'h0000_0400, 1'b0, 32'h0);
    tick(); drop();
    tick();
    vec_cnt++; if (M_strobe_o !== 1'b1) begin err_cnt++; $display("FAIL race_mstrobe: got %b want 1", M_strobe_o); end
    tick_n(15);
    vec_cnt++; if (S1_data_ready_o !== 1'b0) begin err_cnt++; $display("FAIL race_early: got %b want 0", S1_data_ready_o); end
    respond(32'hA5A5_1234);
    vec_cnt++; if (S1_data_ready_o !== 1'b1 || S1_error_o !== 1'b0) begin err_cnt++; $display("FAIL race_pulse: got %b/%b want 1/0", S1_data_ready_o, S1_error_o); end
    vec_cnt++; if (S1_data_o !== 32'hA5A5_1234) begin err_cnt++; $display("FAIL race_data: got %h want a5a51234", S1_data_o); end
    tick_n(2);
    vec_cnt++; if (rdy1_cnt !== 1) begin err_cnt++; $display("FAIL race_pulses: got %0d want 1", rdy1_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    clear_counts();
    req0(32'h0000_0500, 1'b1, 32'h77);
    tick(); drop();
    tick();
    tick_n(3);
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if (M_addr_o !== 32'h0 || M_data_o !== 32'h0 || M_rw_o !== 1'b0 || M_byte_enable_o !== 4'h0) begin err_cnt++; $display("FAIL rmw_mfields: got %h/%h/%b/%h want 0/0/0/0", M_addr_o, M_data_o, M_rw_o, M_byte_enable_o); end
    vec_cnt++; if (S0_data_o !== 32'h0 || S1_data_o !== 32'h0) begin err_cnt++; $display("FAIL rmw_sdata: got %h/%h want 0/0", S0_data_o, S1_data_o); end
    vec_cnt++; if (dbg_state_o !== 2'd0) begin err_cnt++; $display("FAIL rmw_state: got %0d want 0", dbg_state_o); end
    tick();
    rst_n = 1'b1;
    tick();
    respond(32'hBAD0_BAD0);
    tick();
    req1(32'h0000_0600, 1'b0, 32'h0);
    tick(); drop();
    vec_cnt++; if (M_strobe_o !== 1'b0) begin err_cnt++; $display("FAIL rmw_t1: got %b want 0", M_strobe_o); end
    tick();
    vec_cnt++; if (M_strobe_o !== 1'b1 || M_addr_o !== 32'h600) begin err_cnt++; $display("FAIL rmw_t2: got %b/%h want 1/00000600", M_strobe_o, M_addr_o); end
    tick();
    respond(32'h0060_0600);
    vec_cnt++; if (S1_data_ready_o !== 1'b1 || S1_data_o !== 32'h0060_0600) begin err_cnt++; $display("FAIL rmw_done: got %b/%h want 1/00600600", S1_data_ready_o, S1_data_o); end
    tick_n(2);
    vec_cnt++; if (rdy0_cnt !== 0 || rdy1_cnt !== 1) begin err_cnt++; $display("FAIL rmw_pulses: got %0d/%0d want 0/1", rdy0_cnt, rdy1_cnt); end
  endtask

  task automatic test_dup_strobe();
    clear_counts();
    req1(32'h0000_0700, 1'b0, 32'h0);
    tick(); drop();
    tick();
    // S1 owns the port; S0's request waits in its latch.
    req0(32'h0000_0004, 1'b0, 32'h0);
    tick();
    S0_addr_i = 32'h0000_0008;
    tick(); drop();
    tick_n(2);
    respond(32'h0000_0077);
    tick();
    vec_cnt++; if (M_strobe_o !== 1'b1 || M_addr_o !== 32'h4) begin err_cnt++; $display("FAIL dup_addr: got %b/%h want 1/00000004", M_strobe_o, M_addr_o); end
    tick();
    respond(32'hCAFE_0004);
    vec_cnt++; if (S0_data_ready_o !== 1'b1 || S0_data_o !== 32'hCAFE_0004) begin err_cnt++; $display("FAIL dup_done: got %b/%h want 1/cafe0004", S0_data_ready_o, S0_data_o); end
    tick_n(20);
    vec_cnt++; if (mstb_cnt !== 2 || rdy0_cnt !== 1 || rdy1_cnt !== 1) begin err_cnt++; $display("FAIL dup_count: got %0d/%0d/%0d want 2/1/1", mstb_cnt, rdy0_cnt, rdy1_cnt); end
    vec_cnt++; if (dbg_state_o !== 2'd0) begin err_cnt++; $display("FAIL dup_idle: got %0d want 0", dbg_state_o); end
  endtask

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish by 500000 time units, required finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0;
    S0_strobe_i = 1'b0; S1_strobe_i = 1'b0;
    S0_rw_i = 1'b0; S1_rw_i = 1'b0;
    S0_addr_i = '0; S1_addr_i = '0; S0_data_i = '0; S1_data_i = '0;
    S0_byte_enable_i = '0; S1_byte_enable_i = '0;
    M_data_ready_i = 1'b0; M_data_i = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_timeout();
    test_race();
    test_reset_mid_wait();
    test_dup_strobe();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
